// File: rtl/memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder_if
// Description : Memory-side bus between control_matrix and memory_responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_responder_if;
    logic [15:0] instructionPointer;
    logic [25:0] instruction;
    logic        instructionValid;
    logic [15:0] addressIn;
    logic        readValueIn;
    logic [7:0]  valueIn;
    logic        valueInValid;
    logic [15:0] addressOut;
    logic [7:0]  valueOut;
    logic        writeValueOut;
    logic        writeDone;
    logic        loadEnable;
    logic [15:0] loadAddress;
    logic [7:0]  loadData;
    logic        busy;

    modport master (
        output instructionPointer, addressIn, readValueIn, addressOut, valueOut,
               writeValueOut, loadEnable, loadAddress, loadData,
        input  instruction, instructionValid, valueIn, valueInValid, writeDone, busy
    );

    modport slave (
        input  instructionPointer, addressIn, readValueIn, addressOut, valueOut,
               writeValueOut, loadEnable, loadAddress, loadData,
        output instruction, instructionValid, valueIn, valueInValid, writeDone, busy
    );
endinterface
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Byte-wide single-port RAM serving fetches, data reads/writes
//               and host preload, arbitrated by a small FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int DEPTH       = 1024,  // power of two, below 65536
    parameter int INSTR_BYTES = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    memory_responder_if.slave bus
);
    localparam int C_ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FETCH = 2'd3
    } state_t;

    state_t r_state, w_nextState;

    logic                r_readPrev, r_writePrev;
    logic                r_readPend, r_writePend;
    logic [15:0]         r_readAddr, r_writeAddr;
    logic [7:0]          r_writeData;
    logic [15:0]         r_tag, r_fetchIp;
    logic                r_tagValid;
    logic [2:0]          r_cnt;
    logic [2:0][7:0]     r_fetchBuf;
    logic [25:0]         r_instruction;
    logic [7:0]          r_valueIn;
    logic                r_valueInValid, r_writeDone;
    logic [7:0]          r_mem [DEPTH];
    logic [7:0]          r_ramQ;

    logic                w_readEdge, w_writeEdge, w_fetchNeed;
    logic                w_ramWe;
    logic [15:0]         w_ramAddr;
    logic [7:0]          w_ramWdata;
    logic [C_ADDR_W-1:0] w_ramIdx, w_winOffset;
    logic                w_inWindow;
    logic                w_unusedAddrBits;

    assign w_readEdge  = bus.readValueIn & ~r_readPrev;
    assign w_writeEdge = bus.writeValueOut & ~r_writePrev;
    assign w_fetchNeed = !r_tagValid || (r_tag != bus.instructionPointer);

    // Address mod DEPTH is simply the low bits of the 16-bit (wrapped) address
    assign w_ramIdx         = w_ramAddr[C_ADDR_W-1:0];
    assign w_unusedAddrBits = ^w_ramAddr[15:C_ADDR_W];
    assign w_winOffset      = w_ramIdx - r_tag[C_ADDR_W-1:0];
    assign w_inWindow       = r_tagValid && (w_winOffset < C_ADDR_W'(INSTR_BYTES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_ramWe     = 1'b0;
        w_ramAddr   = r_fetchIp + 16'(r_cnt);
        w_ramWdata  = r_writeData;
        case (r_state)
            IDLE: begin
                if (bus.loadEnable) begin
                    w_ramWe    = 1'b1;
                    w_ramAddr  = bus.loadAddress;
                    w_ramWdata = bus.loadData;
                end else if (r_writePend) begin
                    w_nextState = WRITE;
                end else if (r_readPend) begin
                    w_nextState = READ;
                end else if (w_fetchNeed) begin
                    w_nextState = FETCH;
                end
            end
            WRITE: begin
                w_ramWe     = 1'b1;
                w_ramAddr   = r_writeAddr;
                w_nextState = IDLE;
            end
            READ: begin
                w_ramAddr = r_readAddr;
                if (r_cnt == 3'd1) w_nextState = IDLE;
            end
            FETCH: begin
                if (r_cnt == 3'(INSTR_BYTES)) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readPrev     <= 1'b0;
            r_writePrev    <= 1'b0;
            r_readPend     <= 1'b0;
            r_writePend    <= 1'b0;
            r_readAddr     <= '0;
            r_writeAddr    <= '0;
            r_writeData    <= '0;
            r_tag          <= '0;
            r_tagValid     <= 1'b0;
            r_fetchIp      <= '0;
            r_cnt          <= '0;
            r_fetchBuf     <= '0;
            r_instruction  <= '0;
            r_valueIn      <= '0;
            r_valueInValid <= 1'b0;
            r_writeDone    <= 1'b0;
        end else begin
            r_readPrev     <= bus.readValueIn;
            r_writePrev    <= bus.writeValueOut;
            r_valueInValid <= 1'b0;
            r_writeDone    <= 1'b0;
            r_cnt <= (r_state == w_nextState && r_state != IDLE) ? r_cnt + 3'd1 : 3'd0;

            if (r_state == WRITE) begin
                r_writePend <= 1'b0;
                r_writeDone <= 1'b1;
            end
            if (r_state == READ && r_cnt == 3'd1) begin
                r_readPend     <= 1'b0;
                r_valueIn      <= r_ramQ;
                r_valueInValid <= 1'b1;
            end
            // A fresh edge in the completion cycle re-arms the request
            if (w_writeEdge) begin
                r_writePend <= 1'b1;
                r_writeAddr <= bus.addressOut;
                r_writeData <= bus.valueOut;
            end
            if (w_readEdge) begin
                r_readPend <= 1'b1;
                r_readAddr <= bus.addressIn;
            end

            if (r_state == IDLE && w_nextState == FETCH) r_fetchIp <= bus.instructionPointer;
            if (r_state == FETCH) begin
                if (r_cnt == 3'(INSTR_BYTES)) begin
                    r_instruction <= {r_fetchBuf[0][1:0], r_fetchBuf[1], r_fetchBuf[2], r_ramQ};
                    r_tag         <= r_fetchIp;
                    r_tagValid    <= 1'b1;
                end else if (r_cnt != 3'd0) begin
                    r_fetchBuf[2'(r_cnt - 3'd1)] <= r_ramQ;
                end
            end
            if (w_ramWe && w_inWindow) r_tagValid <= 1'b0;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clock) begin
        if (w_ramWe) r_mem[w_ramIdx] <= w_ramWdata;
        r_ramQ <= r_mem[w_ramIdx];
    end

    assign bus.instruction      = r_instruction;
    assign bus.instructionValid = r_tagValid && (r_tag == bus.instructionPointer);
    assign bus.valueIn          = r_valueIn;
    assign bus.valueInValid     = r_valueInValid;
    assign bus.writeDone        = r_writeDone;
    assign bus.busy             = (r_state != IDLE) || r_readPend || r_writePend;
endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Self-checking bench for memory_responder (vector table plus
//               scoreboard of expected read data and write completions).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memory_responder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    memory_responder_if bus ();

    memory_responder #(.DEPTH(1024), .INSTR_BYTES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          isWrite;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  expRead;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] img  [7];
    logic [7:0] readQ [$];
    int         writeQ [$];
    int         nVec = 0;
    int         nErr = 0;
    int         nWriteDone = 0;
    time        tWd = 0;
    time        tRd = 0;
    int         lat;
    int         wd0;
    bit         sawDrop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: completions are matched against what was queued at drive time
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.writeDone) begin
                nWriteDone++;
                tWd = $time;
                check("wr_pending", 32'(writeQ.size() > 0), 1);
                if (writeQ.size() > 0) void'(writeQ.pop_front());
            end
            if (bus.valueInValid) begin
                tRd = $time;
                check("rd_pending", 32'(readQ.size() > 0), 1);
                if (readQ.size() > 0) check("read_data", 32'(bus.valueIn), 32'(readQ.pop_front()));
            end
        end
    end

    task automatic waitDone();
        for (int k = 0; k < 40; k++) begin
            if (readQ.size() == 0 && writeQ.size() == 0 && !bus.busy) return;
            tick();
        end
        check("done_timeout", 32'(readQ.size() + writeQ.size()), 0);
        readQ.delete();
        writeQ.delete();
    endtask

    task automatic waitValid(output int latency);
        latency = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.instructionValid) begin
                latency = k + 1;
                return;
            end
        end
        check("valid_timeout", 32'(bus.instructionValid), 1);
    endtask

    task automatic applyOp(input vec_t v);
        if (v.isWrite) begin
            bus.addressOut    = v.addr;
            bus.valueOut      = v.data;
            bus.writeValueOut = 1'b1;
            writeQ.push_back(1);
        end else begin
            bus.addressIn   = v.addr;
            bus.readValueIn = 1'b1;
            readQ.push_back(v.expRead);
        end
        tick();
        bus.writeValueOut = 1'b0;
        bus.readValueIn   = 1'b0;
        waitDone();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_instruction"}, 32'(bus.instruction), 0);
        check({tag, "_instrValid"},  32'(bus.instructionValid), 0);
        check({tag, "_valueIn"},     32'(bus.valueIn), 0);
        check({tag, "_valueInValid"}, 32'(bus.valueInValid), 0);
        check({tag, "_writeDone"},   32'(bus.writeDone), 0);
        check({tag, "_busy"},        32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        img  = '{8'h40, 8'h12, 8'h34, 8'h56, 8'h9C, 8'hDE, 8'hF1};
        vecs = '{
            '{1'b1, 16'h0020, 8'h11, 8'h00},
            '{1'b1, 16'h0021, 8'h22, 8'h00},
            '{1'b0, 16'h0020, 8'h00, 8'h11},
            '{1'b0, 16'h0021, 8'h00, 8'h22},
            '{1'b0, 16'h0003, 8'h00, 8'h56},
            '{1'b1, 16'h0420, 8'h99, 8'h00},
            '{1'b0, 16'h0020, 8'h00, 8'h99},
            '{1'b0, 16'hFC21, 8'h00, 8'h22},
            '{1'b1, 16'h03FF, 8'h5A, 8'h00},
            '{1'b1, 16'h03FE, 8'h7B, 8'h00},
            '{1'b0, 16'h03FE, 8'h00, 8'h7B}
        };

        bus.instructionPointer = 16'h0300;
        bus.addressIn     = '0;
        bus.readValueIn   = 1'b0;
        bus.addressOut    = '0;
        bus.valueOut      = '0;
        bus.writeValueOut = 1'b0;
        bus.loadEnable    = 1'b0;
        bus.loadAddress   = '0;
        bus.loadData      = '0;
        reset             = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Let the power-up fetch of an unloaded window settle, then preload
        waitValid(lat);
        for (int i = 0; i < 7; i++) begin
            bus.loadEnable  = 1'b1;
            bus.loadAddress = 16'(i);
            bus.loadData    = img[i];
            tick();
        end
        bus.loadEnable = 1'b0;
        tick();

        bus.instructionPointer = 16'h0000;
        waitValid(lat);
        check("fetch_latency", 32'(lat), 7);
        check("instr_ip0", 32'(bus.instruction), 32'h0123456);

        foreach (vecs[i]) applyOp(vecs[i]);

        // Same-cycle write and read to one address
        bus.addressOut    = 16'h0010;
        bus.valueOut      = 8'hAB;
        bus.writeValueOut = 1'b1;
        bus.addressIn     = 16'h0010;
        bus.readValueIn   = 1'b1;
        writeQ.push_back(1);
        readQ.push_back(8'hAB);
        tick();
        bus.writeValueOut = 1'b0;
        bus.readValueIn   = 1'b0;
        waitDone();
        check("write_before_read", 32'(tWd < tRd), 1);

        // Fetch window wrapping past the end of the RAM
        bus.instructionPointer = 16'h03FE;
        waitValid(lat);
        check("instr_wrap", 32'(bus.instruction), 32'h35A4012);

        // IP moves while a fetch is in flight
        bus.instructionPointer = 16'h0000;
        tick();
        tick();
        bus.instructionPointer = 16'h0003;
        waitValid(lat);
        check("instr_ip3", 32'(bus.instruction), 32'h29CDEF1);
        check("refetch_latency_gt7", 32'(lat > 7), 1);

        // Level-held write into the live fetch window
        wd0     = nWriteDone;
        sawDrop = 1'b0;
        bus.addressOut    = 16'h0005;
        bus.valueOut      = 8'h33;
        bus.writeValueOut = 1'b1;
        writeQ.push_back(1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.instructionValid) sawDrop = 1'b1;
        end
        bus.writeValueOut = 1'b0;
        waitDone();
        check("single_writeDone", 32'(nWriteDone - wd0), 1);
        check("valid_dropped", 32'(sawDrop), 1);
        waitValid(lat);
        check("instr_after_write", 32'(bus.instruction), 32'h29C33F1);

        // Asynchronous reset in the middle of a fetch
        bus.instructionPointer = 16'h0000;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        tick();
        reset = 1'b0;
        waitValid(lat);
        check("reset_refetch_latency", 32'(lat), 7);
        check("instr_after_reset", 32'(bus.instruction), 32'h0123456);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Byte-wide memory responder on the far side of the control_matrix memory interface.
- Serves instruction fetches addressed by instructionPointer, byte data reads (addressIn/readValueIn → valueIn) and byte writes (addressOut/valueOut/writeValueOut) from one internal single-port RAM.
- A host load port preloads program and data.
- Arbitrates all requests, then returns data with valid/done pulses.

Parameters:
- DEPTH, 1024: RAM bytes; byte address = 16-bit address mod DEPTH.
- INSTR_BYTES, 4: bytes per fetch; fixed at 4 (26-bit instruction packed into 32 bits).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- instructionPointer  input  16  byte address of the instruction to fetch
- instruction  output  26  {b0[1:0],b1,b2,b3}, where b0..b3 are the bytes at IP..IP+3 (b0 at IP)
- instructionValid  output  1  high while instruction matches the current instructionPointer
- addressIn  input  16  data read address
- readValueIn  input  1  read request; rising edge starts a read
- valueIn  output  8  read data; held until the next read completes
- valueInValid  output  1  one-cycle pulse when valueIn is updated
- addressOut  input  16  write address
- valueOut  input  8  write data
- writeValueOut  input  1  write request; rising edge starts a write
- writeDone  output  1  one-cycle pulse after the write commits
- loadEnable  input  1  host write strobe, level (one byte per cycle)
- loadAddress  input  16  host write address
- loadData  input  8  host write data
- busy  output  1  high when state≠IDLE or any request is pending

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0; state→IDLE.
  - Pending flags, edge detectors and fetch tag are cleared; tag is marked invalid.
  - RAM contents are not reset.
  - Reset mid-operation aborts the operation; pending requests are lost.
- RAM: one access per cycle, registered read; data is available the cycle after the address is presented.
- Request capture:
  - Rising edges of readValueIn and writeValueOut are detected against the previous-cycle sample.
  - Each edge sets a pending flag with its address/data latched at the edge.
  - A second edge while a request is still pending overwrites the latched values; only one request of each kind is pending.
- Fetch need: fetch is required when the tag is invalid or tag≠instructionPointer.
  - instructionValid is combinationally low whenever tag≠instructionPointer.
- Arbitration in IDLE, highest priority first: loadEnable > pending write > pending read > fetch need.
- FSM states: IDLE, WRITE, READ, FETCH.
- IDLE:
  - loadEnable: RAM write in the same cycle; stay in IDLE.
  - Otherwise the highest pending request moves the FSM to its state.
- WRITE: 1 cycle; commits the RAM write. writeDone pulses the next cycle; flag cleared; →IDLE.
- READ: 2 cycles (address, capture). valueIn is updated and valueInValid pulses the cycle after capture; flag cleared; →IDLE.
- FETCH:
  - IP is latched at entry.
  - Addresses IP+0..IP+3 are issued on consecutive cycles; bytes are captured pipelined; 5 cycles total.
  - On completion: instruction and tag are updated; →IDLE.
  - instructionValid rises on the first cycle the tag equals instructionPointer.
  - If IP changed during the fetch, valid stays low and a refetch begins from IDLE.
- Latency from instructionPointer change to instructionValid, no contention: 7 cycles (detect + 5 fetch + valid).
- Requests arriving during FETCH/READ/WRITE stay pending and are served in priority order after return to IDLE; loadEnable is ignored outside IDLE.
- Simultaneous write and read edges: write is served first, so the read returns the newly written byte when addresses match.
- Address arithmetic: IP+k wraps at 16 bits, then mod DEPTH (e.g. IP=0xFFFF reads 0xFFFF,0x0000,0x0001,0x0002, each mod DEPTH).
- A write into the current tag's 4-byte window invalidates the tag, which forces a refetch.

Test Plan:
- Reset mid-FETCH: reset asserted → all outputs 0 immediately, busy=0; after release, a refetch occurs.
- Load bytes 0x40,0x12,0x34,0x56 at 0..3, IP=0 → instructionValid at cycle 7, instruction=0x0123456.
- Write 0xAB to 0x0010 and read 0x0010 with edges in the same cycle → writeDone pulses first, then valueInValid with valueIn=0xAB.
- IP changes 0→3 during a fetch → no valid for IP=0; instruction from bytes 3..6 is valid afterwards.
- DEPTH=1024, IP=0x03FE → bytes fetched from 0x3FE,0x3FF,0x000,0x001.
- writeValueOut held high for 10 cycles → exactly one write and one writeDone pulse; write to IP+2 → instructionValid drops, then refetch.
